mem_access_ctrl: RTL and testbench

//  Initiator side of the 16-bit big-endian unified instruction/data memory interface.

---
 rtl/mem_access_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator for the 16-bit big-endian unified instruction/data memory.
// Sequences fetch/load/store with region faults; define MEM_BYTE_ACCESS_EN for byte access (RMW stores).

module mem_access_ctrl #(
  parameter int IMEM_TOP     = 1023,
  parameter int DMEM_BASE    = 1024,
  parameter int MEM_TOP      = 4095,
  parameter int READ_WAIT    = 1,
  parameter int WRITE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_byte,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_fault,
  output logic [15:0] Mem_Address,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [15:0] Write_Data,
  input  logic [15:0] Result
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RD_WAIT, S_WRITE, S_HOLD, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_RSVD = 2'b11
  } op_t;

  localparam int CNT_MAX = (READ_WAIT > WRITE_CYCLES) ? READ_WAIT : WRITE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // 17-bit bounds so addr+1 at 16'hFFFF compares correctly instead of wrapping to 0.
  localparam logic [16:0] IMEM_TOP_X  = 17'(IMEM_TOP);
  localparam logic [16:0] DMEM_BASE_X = 17'(DMEM_BASE);
  localparam logic [16:0] MEM_TOP_X   = 17'(MEM_TOP);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);

  state_t            state, state_d;
  op_t               op_q;
  logic              fault_q;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       data_q;
  logic [16:0]       addr_x, addr_x1;
  logic              word_ok;
  logic              req_fault;
  logic              accept;
  logic              rmw;
  logic              rd_strobe;

  assign addr_x    = {1'b0, req_addr};
  assign addr_x1   = addr_x + 17'd1;
  assign word_ok   = (addr_x >= DMEM_BASE_X) && (addr_x1 <= MEM_TOP_X);
  assign accept    = (state == S_IDLE) && req_valid;

`ifdef MEM_BYTE_ACCESS_EN
  logic byte_q;
  assign rmw = (op_q == OP_STORE) && byte_q;
`else
  assign rmw = 1'b0;
`endif

  // Byte stores read the partner byte first, so they strobe Mem_Read like loads.
  assign rd_strobe = (op_q == OP_LOAD) || rmw;

  // Fault decision is made on the incoming fields and latched with them on accept.
  always_comb begin
    req_fault = 1'b1;
    case (req_op)
      OP_FETCH:          req_fault = (addr_x1 > IMEM_TOP_X);
      OP_LOAD, OP_STORE: req_fault = !word_ok;
      default:           req_fault = 1'b1;
    endcase
`ifdef MEM_BYTE_ACCESS_EN
    if (req_byte) begin
      case (req_op)
        OP_LOAD:  req_fault = !((addr_x >= DMEM_BASE_X) && (addr_x <= MEM_TOP_X));
        OP_STORE: req_fault = !word_ok;
        default:  req_fault = 1'b1;
      endcase
    end
`else
    if (req_byte) req_fault = 1'b1;
`endif
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can infer a latch.
    state_d   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
    rsp_data  = '0;
    rsp_fault = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_fault ? S_RESP : S_SETUP;
      end
      S_SETUP: begin
        Mem_Read = rd_strobe;
        state_d  = ((op_q == OP_STORE) && !rmw) ? S_WRITE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        Mem_Read = rd_strobe;
        if (cnt == RD_LAST) state_d = rmw ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        Mem_Write = 1'b1;
        if (cnt == WR_LAST) state_d = S_HOLD;
      end
      S_HOLD: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = data_q;
        rsp_fault = fault_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state       <= S_IDLE;
      op_q        <= OP_FETCH;
      fault_q     <= 1'b0;
      cnt         <= '0;
      data_q      <= '0;
      Mem_Address <= '0;
      Write_Data  <= '0;
`ifdef MEM_BYTE_ACCESS_EN
      byte_q      <= 1'b0;
`endif
    end else begin
      state <= state_d;
      if (state_d != state) cnt <= '0;
      else if ((state == S_RD_WAIT) || (state == S_WRITE)) cnt <= cnt + CNT_W'(1);

      if (accept) begin
        op_q    <= op_t'(req_op);
        fault_q <= req_fault;
        data_q  <= '0;
`ifdef MEM_BYTE_ACCESS_EN
        byte_q  <= req_byte;
`endif
        // Rejected requests leave the memory bus untouched.
        if (!req_fault) begin
          Mem_Address <= req_addr;
          Write_Data  <= req_wdata;
        end
      end

      if ((state == S_RD_WAIT) && (cnt == RD_LAST)) begin
`ifdef MEM_BYTE_ACCESS_EN
        if (rmw)         Write_Data <= {Write_Data[7:0], Result[7:0]};
        else if (byte_q) data_q     <= {8'h00, Result[15:8]};
        else             data_q     <= Result;
`else
        data_q <= Result;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: bench-owned byte memory plus a transaction-level
// reference model; directed scenarios followed by randomized requests.

module tb_mem_access_ctrl;

  localparam int IMEM_TOP  = 1023;
  localparam int DMEM_BASE = 1024;
  localparam int MEM_TOP   = 4095;
  localparam int RW        = 1;
  localparam int WC        = 1;

  logic        clk = 1'b0;
  logic        rest;
  logic        req_valid, req_ready, req_byte;
  logic [1:0]  req_op;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [15:0] rsp_data;
  logic [15:0] Mem_Address, Write_Data, Result;
  logic        Mem_Read, Mem_Write;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lat; logic [15:0] data; logic fault; int rd_cyc; int wr_cyc;
    int both; int busy; int addr_bad; logic post_valid; logic post_ready; logic timeout;
  } obs_t;

  typedef struct {
    int lat; logic [15:0] data; logic fault; int rd_cyc; int wr_cyc;
  } exp_t;

  mem_access_ctrl #(
    .IMEM_TOP(IMEM_TOP), .DMEM_BASE(DMEM_BASE), .MEM_TOP(MEM_TOP),
    .READ_WAIT(RW), .WRITE_CYCLES(WC)
  ) dut (
    .clk(clk), .rest(rest),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte(req_byte),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .Mem_Address(Mem_Address), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Write_Data(Write_Data), .Result(Result)
  );

  always #5 clk = ~clk;

  // Memory device: big-endian word read, level-sensitive write applied on each strobed edge.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] addr_p1;
  assign addr_p1 = Mem_Address + 16'd1;
  assign Result  = {mem[Mem_Address], mem[addr_p1]};

  always @(posedge clk) begin
    if (Mem_Write) begin
      mem[Mem_Address] = Write_Data[15:8];
      mem[addr_p1]     = Write_Data[7:0];
    end
  end

  // Reference model: decides the outcome of one request from the region rules.
  task automatic model_req(input logic [1:0] op, input logic [15:0] addr,
                           input logic [15:0] wd, input logic byt, output exp_t e);
    int a;
    logic f;
    a = int'(addr);
    if (op == 2'b11) f = 1'b1;
    else if (byt) begin
`ifdef MEM_BYTE_ACCESS_EN
      if (op == 2'b00)      f = 1'b1;
      else if (op == 2'b01) f = (a < DMEM_BASE) || (a > MEM_TOP);
      else                  f = (a < DMEM_BASE) || (a + 1 > MEM_TOP);
`else
      f = 1'b1;
`endif
    end
    else if (op == 2'b00) f = (a + 1 > IMEM_TOP);
    else                  f = (a < DMEM_BASE) || (a + 1 > MEM_TOP);
    e.fault = f; e.lat = 1; e.data = '0; e.rd_cyc = 0; e.wr_cyc = 0;
    if (!f) begin
      if (op == 2'b00) begin
        e.lat = 2 + RW; e.data = {ref_mem[a], ref_mem[a+1]};
      end else if (op == 2'b01) begin
        e.lat = 2 + RW; e.rd_cyc = 1 + RW;
        e.data = byt ? {8'h00, ref_mem[a]} : {ref_mem[a], ref_mem[a+1]};
      end else begin
        e.wr_cyc = WC;
        if (byt) begin
          e.lat = 3 + RW + WC; e.rd_cyc = 1 + RW; ref_mem[a] = wd[7:0];
        end else begin
          e.lat = 3 + WC; ref_mem[a] = wd[15:8]; ref_mem[a+1] = wd[7:0];
        end
      end
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] addr,
                       input logic [15:0] wd, input logic byt);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_byte = byt;
  endtask

  // Observes one transaction starting 1 time unit after its accept edge.
  task automatic collect(input logic [15:0] addr, output obs_t o);
    o.lat = 0; o.data = '0; o.fault = 1'b0; o.rd_cyc = 0; o.wr_cyc = 0;
    o.both = 0; o.busy = 0; o.addr_bad = 0; o.timeout = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (Mem_Read) o.rd_cyc++;
      if (Mem_Write) o.wr_cyc++;
      if (Mem_Read && Mem_Write) o.both++;
      if (req_ready) o.busy++;
      if (rsp_valid) begin
        o.lat = c; o.data = rsp_data; o.fault = rsp_fault;
        break;
      end
      if (Mem_Address !== addr) o.addr_bad++;
      @(posedge clk); #1;
    end
    if (o.lat == 0) o.timeout = 1'b1;
    @(posedge clk); #1;
    o.post_valid = rsp_valid;
    o.post_ready = req_ready;
  endtask

  task automatic run_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                         input logic byt, output obs_t o, output exp_t e);
    model_req(op, addr, wd, byt, e);
    drive(op, addr, wd, byt);
    @(posedge clk); #1;
    req_valid = 1'b0;
    collect(addr, o);
    checks++;
    if (o.timeout) begin
      errors++;
      $display("FAIL timeout op=%0d addr=%h: got no rsp_valid, required one within 40 cycles", op, addr);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({req_ready, rsp_valid, Mem_Read, Mem_Write, rsp_fault} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 10000", {req_ready, rsp_valid, Mem_Read, Mem_Write, rsp_fault});
    end
    checks++;
    if ({Mem_Address, Write_Data, rsp_data} !== 48'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h required 0", {Mem_Address, Write_Data, rsp_data});
    end
    @(negedge clk) rest = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_fetch_load();
    obs_t o; exp_t e;
    run_req(2'b00, 16'h0010, 16'h0, 1'b0, o, e);
    checks++;
    if (o.data !== 16'h1011 || o.fault !== 1'b0 || o.lat != 3 || o.rd_cyc != 0) begin
      errors++;
      $display("FAIL fetch_0010: got data=%h fault=%b lat=%0d rd=%0d required 1011 0 3 0", o.data, o.fault, o.lat, o.rd_cyc);
    end
    checks++;
    if (o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_pulse: got valid=%b ready=%b after rsp, required 0 1", o.post_valid, o.post_ready);
    end
    run_req(2'b01, 16'h0400, 16'h0, 1'b0, o, e);
    checks++;
    if (o.data !== 16'h0001 || o.fault !== 1'b0 || o.lat != 3 || o.rd_cyc != 2) begin
      errors++;
      $display("FAIL load_0400: got data=%h fault=%b lat=%0d rd=%0d required 0001 0 3 2", o.data, o.fault, o.lat, o.rd_cyc);
    end
  endtask

  task automatic test_store();
    obs_t o; exp_t e;
    run_req(2'b10, 16'h0500, 16'hBEEF, 1'b0, o, e);
    checks++;
    if (o.wr_cyc != 1 || o.rd_cyc != 0 || o.lat != 4 || o.addr_bad != 0 || o.data !== 16'h0) begin
      errors++;
      $display("FAIL store_0500: got wr=%0d rd=%0d lat=%0d addr_bad=%0d data=%h required 1 0 4 0 0000",
               o.wr_cyc, o.rd_cyc, o.lat, o.addr_bad, o.data);
    end
    run_req(2'b01, 16'h0500, 16'h0, 1'b0, o, e);
    checks++;
    if (o.data !== 16'hBEEF) begin
      errors++;
      $display("FAIL store_readback: got %h required beef", o.data);
    end
  endtask

  task automatic test_faults();
    obs_t o; exp_t e;
    logic [1:0] op; logic [15:0] addr; logic exp_f;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin op = 2'b10; addr = 16'h0100; exp_f = 1'b1; end
        1: begin op = 2'b00; addr = 16'h0400; exp_f = 1'b1; end
        2: begin op = 2'b01; addr = 16'h0FFF; exp_f = 1'b1; end
        3: begin op = 2'b11; addr = 16'h0800; exp_f = 1'b1; end
        4: begin op = 2'b00; addr = 16'h03FF; exp_f = 1'b1; end
        5: begin op = 2'b01; addr = 16'hFFFF; exp_f = 1'b1; end
        6: begin op = 2'b00; addr = 16'h03FE; exp_f = 1'b0; end
        7: begin op = 2'b01; addr = 16'h0FFE; exp_f = 1'b0; end
        default: begin op = 2'b10; addr = 16'h03FF; exp_f = 1'b1; end
      endcase
      run_req(op, addr, 16'h5A5A, 1'b0, o, e);
      checks++;
      if (o.fault !== exp_f || o.lat != (exp_f ? 1 : 3) || o.data !== e.data) begin
        errors++;
        $display("FAIL fault_case%0d: got fault=%b lat=%0d data=%h required %b %0d %h",
                 i, o.fault, o.lat, o.data, exp_f, exp_f ? 1 : 3, e.data);
      end
      checks++;
      if (exp_f && (o.rd_cyc + o.wr_cyc) != 0) begin
        errors++;
        $display("FAIL fault_strobe%0d: got rd=%0d wr=%0d required 0 0", i, o.rd_cyc, o.wr_cyc);
      end
    end
  endtask

  task automatic test_byte();
    obs_t o; exp_t e;
`ifdef MEM_BYTE_ACCESS_EN
    run_req(2'b10, 16'h0600, 16'h00AA, 1'b1, o, e);
    checks++;
    if (o.fault !== 1'b0 || o.lat != 5 || o.wr_cyc != 1 || o.rd_cyc != 2 || o.both != 0) begin
      errors++;
      $display("FAIL byte_store: got fault=%b lat=%0d wr=%0d rd=%0d both=%0d required 0 5 1 2 0",
               o.fault, o.lat, o.wr_cyc, o.rd_cyc, o.both);
    end
    run_req(2'b01, 16'h0600, 16'h0, 1'b0, o, e);
    checks++;
    if (o.data !== 16'hAA01) begin
      errors++;
      $display("FAIL byte_store_readback: got %h required aa01", o.data);
    end
    run_req(2'b01, 16'h0601, 16'h0, 1'b1, o, e);
    checks++;
    if (o.data !== 16'h0001 || o.lat != 3) begin
      errors++;
      $display("FAIL byte_load_0601: got %h lat=%0d required 0001 3", o.data, o.lat);
    end
    run_req(2'b01, 16'h0FFF, 16'h0, 1'b1, o, e);
    checks++;
    if (o.data !== 16'h00FF || o.fault !== 1'b0) begin
      errors++;
      $display("FAIL byte_load_top: got %h fault=%b required 00ff 0", o.data, o.fault);
    end
    run_req(2'b10, 16'h0FFF, 16'h0011, 1'b1, o, e);
    checks++;
    if (o.fault !== 1'b1 || o.lat != 1 || o.wr_cyc != 0) begin
      errors++;
      $display("FAIL byte_store_top: got fault=%b lat=%0d wr=%0d required 1 1 0", o.fault, o.lat, o.wr_cyc);
    end
`else
    for (int i = 0; i < 3; i++) begin
      run_req(2'(i), 16'h0600, 16'h00AA, 1'b1, o, e);
      checks++;
      if (o.fault !== 1'b1 || o.lat != 1 || (o.rd_cyc + o.wr_cyc) != 0) begin
        errors++;
        $display("FAIL byte_disabled_op%0d: got fault=%b lat=%0d strobes=%0d required 1 1 0",
                 i, o.fault, o.lat, o.rd_cyc + o.wr_cyc);
      end
    end
`endif
    run_req(2'b00, 16'h0010, 16'h0, 1'b1, o, e);
    checks++;
    if (o.fault !== 1'b1 || o.lat != 1) begin
      errors++;
      $display("FAIL byte_fetch: got fault=%b lat=%0d required 1 1", o.fault, o.lat);
    end
  endtask

  task automatic test_back_to_back();
    obs_t oa, ob; exp_t ea, eb;
    model_req(2'b01, 16'h0400, 16'h0, 1'b0, ea);
    drive(2'b01, 16'h0400, 16'h0, 1'b0);
    @(posedge clk); #1;
    req_op = 2'b00; req_addr = 16'h0010;
    collect(16'h0400, oa);
    checks++;
    if (oa.data !== 16'h0001 || oa.lat != 3 || oa.busy != 0) begin
      errors++;
      $display("FAIL b2b_first: got data=%h lat=%0d ready_while_busy=%0d required 0001 3 0", oa.data, oa.lat, oa.busy);
    end
    checks++;
    if (oa.post_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_ready: got %b required 1", oa.post_ready);
    end
    model_req(2'b00, 16'h0010, 16'h0, 1'b0, eb);
    @(posedge clk); #1;
    req_valid = 1'b0;
    collect(16'h0010, ob);
    checks++;
    if (ob.data !== eb.data || ob.lat != eb.lat || ob.fault !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got data=%h lat=%0d fault=%b required %h %0d 0", ob.data, ob.lat, ob.fault, eb.data, eb.lat);
    end
  endtask

  task automatic test_reset_in_write();
    drive(2'b10, 16'h0700, 16'h1234, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Mem_Write !== 1'b1) begin
      errors++;
      $display("FAIL rst_write_entry: got Mem_Write=%b required 1", Mem_Write);
    end
    #2 rest = 1'b0;
    #1;
    checks++;
    if (Mem_Write !== 1'b0) begin
      errors++;
      $display("FAIL rst_write_drop: got Mem_Write=%b required 0", Mem_Write);
    end
    @(negedge clk) rest = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || Mem_Write !== 1'b0) begin
      errors++;
      $display("FAIL rst_write_release: got ready=%b valid=%b wr=%b required 1 0 0", req_ready, rsp_valid, Mem_Write);
    end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [1:0] op; logic [15:0] addr, wd; logic byt;
    for (int i = 0; i < 120; i++) begin
      op  = 2'($urandom_range(0, 3));
      byt = ($urandom_range(0, 3) == 0);
      wd  = 16'($urandom);
      case ($urandom_range(0, 4))
        0: addr = 16'($urandom_range(0, 1100));
        1: addr = 16'($urandom_range(1018, 1030));
        2: addr = 16'($urandom_range(4085, 4100));
        3: addr = 16'($urandom_range(65530, 65535));
        default: addr = 16'($urandom_range(1024, 4095));
      endcase
      run_req(op, addr, wd, byt, o, e);
      checks++;
      if (o.fault !== e.fault || o.data !== e.data || o.lat != e.lat) begin
        errors++;
        $display("FAIL rand%0d op=%0d addr=%h byte=%b: got fault=%b data=%h lat=%0d required %b %h %0d",
                 i, op, addr, byt, o.fault, o.data, o.lat, e.fault, e.data, e.lat);
      end
      checks++;
      if (o.rd_cyc != e.rd_cyc || o.wr_cyc != e.wr_cyc || o.both != 0 || o.addr_bad != 0) begin
        errors++;
        $display("FAIL rand%0d_bus: got rd=%0d wr=%0d both=%0d addr_bad=%0d required %0d %0d 0 0",
                 i, o.rd_cyc, o.wr_cyc, o.both, o.addr_bad, e.rd_cyc, e.wr_cyc);
      end
      checks++;
      if (o.busy != 0 || o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_hs: got busy=%0d post_valid=%b post_ready=%b required 0 0 1",
                 i, o.busy, o.post_valid, o.post_ready);
      end
    end
  endtask

  initial begin
    rest = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_addr = '0; req_wdata = '0; req_byte = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
    test_reset();
    test_fetch_load();
    test_store();
    test_faults();
    test_byte();
    test_back_to_back();
    test_reset_in_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
